// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op and access-size
// encodings, FSM state encoding, the latched op-attribute record and the
// alignment predicate used when an op is accepted.
package ysyx_22040237_lsu_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] size;
    logic       uns;
  } op_attr_t;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      SIZE_D:  return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_if.sv
// Bundle of all handshake/bus signals around the LSU.
//   in_*      : execute -> LSU op (valid/ready)
//   mem_req_* : LSU -> data memory request (valid/ready)
//   mem_rsp_* : data memory -> LSU response (valid pulse)
//   out_*     : LSU -> writeback result (valid/ready)
// modport master is the LSU's view; modport slave is the surrounding
// pipeline and memory.
interface ysyx_22040237_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [1:0]        in_mem_op;
  logic [1:0]        in_size;
  logic              in_unsigned;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [7:0]        mem_req_wmask;

  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic              out_err;

  modport master (
    input  in_valid, in_addr, in_wdata, in_mem_op, in_size, in_unsigned,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata,
    output out_valid, out_data, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_mem_op, in_size, in_unsigned,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata,
    input  out_valid, out_data, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22040237_lsu_align.sv
// Combinational byte-lane alignment between an 8-byte memory word and a
// naturally sized access.
//   size_i, off_i    : access size and byte offset inside the 8-byte word
//   uns_i            : zero-extend load result when 1
//   st_data_i        : store data (rs2), low bytes significant
//   st_mask_o        : byte-lane write mask
//   st_data_o        : store data moved into its byte lanes
//   ld_data_i        : aligned 8-byte read data
//   ld_data_o        : extracted and sign/zero-extended load value
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [7:0]      st_mask_o,
  output logic [XLEN-1:0] st_data_o,
  input  logic [XLEN-1:0] ld_data_i,
  output logic [XLEN-1:0] ld_data_o
);

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] v,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (size)
      SIZE_B:  return uns ? XLEN'(v[7:0])  : XLEN'(b);
      SIZE_H:  return uns ? XLEN'(v[15:0]) : XLEN'(h);
      SIZE_W:  return uns ? XLEN'(v[31:0]) : XLEN'(w);
      default: return v;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_truncate(input logic [XLEN-1:0] v,
                                                     input logic [1:0] size);
    case (size)
      SIZE_B:  return XLEN'(v[7:0]);
      SIZE_H:  return XLEN'(v[15:0]);
      SIZE_W:  return XLEN'(v[31:0]);
      default: return v;
    endcase
  endfunction

  logic [7:0]      base_mask;
  logic [5:0]      bit_off;
  logic [XLEN-1:0] ld_shifted;

  assign bit_off = {off_i, 3'b000};

  always_comb begin
    base_mask = 8'h01;
    case (size_i)
      SIZE_H:  base_mask = 8'h03;
      SIZE_W:  base_mask = 8'h0F;
      SIZE_D:  base_mask = 8'hFF;
      default: base_mask = 8'h01;
    endcase
  end

  assign st_mask_o  = base_mask << off_i;
  assign st_data_o  = store_truncate(st_data_i, size_i) << bit_off;
  assign ld_shifted = ld_data_i >> bit_off;
  assign ld_data_o  = load_extend(ld_shifted, size_i, uns_i);

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store stage: accepts one execute result at a time, performs at most
// one data-memory transaction (valid/ready request, valid-pulse response)
// and hands a 64-bit writeback value on a valid/ready output.
//   clk, rst : clock, synchronous active-high reset
//   bus      : all handshake/bus signals (master view, see lsu_if)
// Datapath registers are not reset; every bus output is gated by the FSM
// state so that all outputs read as zero outside the state that owns them.
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22040237_lsu_if.master  bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  op_attr_t          attr_q;
  logic [XLEN-1:0]   out_data_q;
  logic              out_err_q;

  logic              accept;
  logic              in_is_mem;
  logic              in_misaligned;
  logic              rsp_take;
  logic              in_req;
  logic              is_store;
  logic [7:0]        st_mask;
  logic [XLEN-1:0]   st_data;
  logic [XLEN-1:0]   ld_data;

  assign accept        = (state_q == ST_IDLE) && bus.in_valid;
  assign in_is_mem     = (bus.in_mem_op == MEM_OP_LOAD) || (bus.in_mem_op == MEM_OP_STORE);
  assign in_misaligned = is_misaligned(bus.in_size, bus.in_addr[2:0]);
  assign rsp_take      = (state_q == ST_WAIT) && bus.mem_rsp_valid;
  assign in_req        = (state_q == ST_REQ);
  assign is_store      = (attr_q.op == MEM_OP_STORE);

  ysyx_22040237_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i    (attr_q.size),
    .uns_i     (attr_q.uns),
    .off_i     (addr_q[2:0]),
    .st_data_i (wdata_q),
    .st_mask_o (st_mask),
    .st_data_o (st_data),
    .ld_data_i (bus.mem_rsp_rdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = (in_is_mem && !in_misaligned) ? ST_REQ : ST_DONE;
      ST_REQ:  if (bus.mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (bus.mem_rsp_valid) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Op capture on accept; result capture on memory response.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q      <= bus.in_addr[ADDR_W-1:0];
      wdata_q     <= bus.in_wdata;
      attr_q.op   <= bus.in_mem_op;
      attr_q.size <= bus.in_size;
      attr_q.uns  <= bus.in_unsigned;
      // Pass-through and misaligned ops both report the incoming value;
      // an aligned memory op overwrites it when the response arrives.
      out_data_q  <= bus.in_addr;
      out_err_q   <= in_is_mem && in_misaligned;
    end else if (rsp_take) begin
      out_data_q  <= is_store ? '0 : ld_data;
    end
  end

  assign bus.in_ready      = (state_q == ST_IDLE);
  assign bus.mem_req_valid = in_req;
  assign bus.mem_req_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.mem_req_wen   = in_req && is_store;
  assign bus.mem_req_wdata = (in_req && is_store) ? st_data : '0;
  assign bus.mem_req_wmask = (in_req && is_store) ? st_mask : '0;
  assign bus.out_valid     = (state_q == ST_DONE);
  assign bus.out_data      = (state_q == ST_DONE) ? out_data_q : '0;
  assign bus.out_err       = (state_q == ST_DONE) && out_err_q;

endmodule
